decode_pipe: RTL and testbench
==============================

DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 The block SHALL have one parameter, WIDTH, default 4, giving the decode lanes per cycle; legal values are 1..8.
REQ-002 The block SHALL have one derived localparam, CW, equal to $clog2(WIDTH+1), giving the count-field width (3 when WIDTH=4).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 Port: clk  in  1  rising-edge clock.
REQ-005 Port: rst  in  1  asynchronous, active-high reset.
REQ-006 Port: flush  in  1  discards all buffered and incoming lanes.
REQ-007 Port: in_valid  in  WIDTH  per-lane valid for decode_require.
REQ-008 Port: decode_require  in  WIDTH x DECODE_REQUIRE  fetched instruction lanes.
REQ-009 Port: in_ready  out  1  the block accepts the input bundle this cycle.
REQ-010 Port: issue_queue_element  out  WIDTH x ISSUE_QUEUE_ELEMENT  decoded lanes to the issue queue.
REQ-011 Port: issue_queue_push_number  out  CW  number of lanes the issue queue takes this cycle.
REQ-012 Port: iq_size_left  in  CW  free issue-queue slots.
REQ-013 Port: stall_count  out  32  cycles in which buffered lanes were blocked.

Function
REQ-014 Each input lane SHALL be decoded by one instance of the existing decoder sub-block; decoding is combinational before capture.
REQ-015 Valid lanes SHALL be compacted into a buffer of WIDTH entries, at the lowest indices and in ascending input-lane order, regardless of gaps in in_valid.
REQ-016 The buffer state SHALL be a contiguous occupancy count, occ (0..WIDTH), plus the WIDTH buffered elements.
REQ-017 Latency SHALL be 1 cycle: a lane accepted at edge t is visible on issue_queue_element after edge t.
REQ-018 issue_queue_element[k] SHALL be buffer entry k when k < occ and all-zero otherwise; the output is driven from registers, not from the decoder.
REQ-019 issue_queue_push_number SHALL be combinational: min(occ, min(iq_size_left, WIDTH)) when flush=0, and 0 when flush=1.
REQ-020 Lanes 0..push_number-1 SHALL be treated as consumed at the next edge.
REQ-021 Surviving entries SHALL shift down by push_number at the next edge, preserving order; this is a partial push.
REQ-022 in_ready SHALL equal (occ - push_number == 0) && !flush.
REQ-023 When in_ready=1 and in_valid is non-zero, the compacted decoded lanes SHALL load the buffer and occ SHALL be set to popcount(in_valid).
REQ-024 When in_ready=1 and in_valid is zero, occ SHALL become 0.
REQ-025 When in_ready=0, inputs SHALL be ignored; the upstream stage holds decode_require stable.
REQ-026 Flush SHALL set occ to 0 at the next edge, push nothing in the flush cycle, and drop the input bundle presented in that cycle.
REQ-027 Flush SHALL take priority over push and load.
REQ-028 stall_count SHALL increment by 1 at each edge where flush=0, occ>0 and push_number<occ.
REQ-029 stall_count SHALL saturate at 32'hFFFF_FFFF and is cleared only by reset.
REQ-030 iq_size_left values greater than WIDTH SHALL be treated as WIDTH.
REQ-031 When iq_size_left=0 and occ>0, the buffer SHALL be held unchanged and in_ready SHALL be 0.

Reset
REQ-032 While rst=1, occ SHALL be 0 and every issue_queue_element SHALL be zero.
REQ-033 While rst=1, issue_queue_push_number SHALL be 0 and stall_count SHALL be 0.
REQ-034 in_ready SHALL be 1 from the first cycle after rst deasserts.
REQ-035 Reset asserted mid-operation SHALL discard buffered lanes immediately (asynchronously); no partial push completes.

Verification
REQ-036 Full throughput: WIDTH=4, in_valid=4'b1111 every cycle, iq_size_left=4 -> push_number=4 every cycle after the first, in_ready constantly 1, stall_count stays 0.
REQ-037 Partial push: buffer holds A,B,C,D and iq_size_left=1 -> push 1 (A), in_ready=0; next cycle B,C,D at lanes 0..2 with push_number min(3, iq_size_left).
REQ-038 Compaction: in_valid=4'b1010 with lanes X1,X3 -> next cycle lane0=X1, lane1=X3, lanes 2..3 zero, push_number=2 when iq_size_left>=2.
REQ-039 Flush: occ=3 and flush=1 with a valid input bundle -> push_number=0 that cycle, occ=0 after the edge, input bundle dropped, stall_count unchanged.
REQ-040 Blocked queue: occ=2 and iq_size_left=0 for 5 cycles -> outputs held, in_ready=0, stall_count increases by 5.
REQ-041 Saturation and reset: stall_count preloaded near 32'hFFFF_FFFF, then stalled -> holds at the maximum; asserting rst mid-stall -> all outputs zero immediately.

Source files
------------

// File: rtl/decode_pipe.sv
// decode_pipe: decodes up to WIDTH fetched instruction lanes per cycle and
// compacts the valid ones into a WIDTH-entry buffer. The buffer drains into
// the issue queue by partial push, and a new bundle is accepted only when
// the buffer empties in the same cycle.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   flush                    drop buffered and incoming lanes
//   in_valid[WIDTH]          per-lane valid
//   decode_require           WIDTH x 32-bit instruction lanes (lane 0 in LSBs)
//   in_ready                 input bundle is accepted this cycle
//   issue_queue_element      WIDTH x 34-bit decoded lanes (registered)
//   issue_queue_push_number  lanes the issue queue takes this cycle
//   iq_size_left             free issue-queue slots
//   stall_count              saturating count of blocked cycles
//
// Decoded element layout (MSB..LSB):
//   [33] valid  [32:31] fu  [30] writes_rd  [29:25] rd  [24:20] rs1
//   [19:15] rs2 [14:12] funct3  [11:0] imm
//   fu: 0 = ALU (OP/OP-IMM), 1 = LSU (LOAD/STORE), 2 = BRANCH, 3 = other

// Single-lane combinational decoder.
module decode_lane (
  input  logic [31:0] instr,
  output logic [33:0] elem
);

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;

  logic [1:0]  fu;
  logic        writes_rd;
  logic [11:0] imm;

  always_comb begin
    fu        = 2'd3;
    writes_rd = 1'b1;
    imm       = instr[31:20];
    case (instr[6:0])
      OPC_OP, OPC_OP_IMM: fu = 2'd0;
      OPC_LOAD:           fu = 2'd1;
      OPC_STORE: begin
        fu        = 2'd1;
        writes_rd = 1'b0;
        imm       = {instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        fu        = 2'd2;
        writes_rd = 1'b0;
      end
      default: ;
    endcase
    elem = {1'b1, fu, writes_rd, instr[11:7], instr[19:15], instr[24:20],
            instr[14:12], imm};
  end

endmodule

module decode_pipe #(
  parameter  int unsigned WIDTH = 4,
  localparam int unsigned CW    = $clog2(WIDTH + 1),
  localparam int unsigned DR_W  = 32,
  localparam int unsigned IQ_W  = 34
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       in_valid,
  input  logic [WIDTH*DR_W-1:0]  decode_require,
  output logic                   in_ready,
  output logic [WIDTH*IQ_W-1:0]  issue_queue_element,
  output logic [CW-1:0]          issue_queue_push_number,
  input  logic [CW-1:0]          iq_size_left,
  output logic [31:0]            stall_count
);

  logic [IQ_W-1:0] dec       [WIDTH];
  logic [IQ_W-1:0] comp      [WIDTH];
  logic [IQ_W-1:0] shifted   [WIDTH];
  logic [IQ_W-1:0] buf_d     [WIDTH];
  logic [IQ_W-1:0] buf_q     [WIDTH];
  logic [CW-1:0]   occ_d, occ_q;
  logic [CW-1:0]   iq_lim, push, load_cnt;
  logic [31:0]     stall_count_d, stall_count_q;

  // One decoder per input lane.
  for (genvar i = 0; i < WIDTH; i++) begin : g_dec
    decode_lane u_dec (
      .instr (decode_require[i*DR_W +: DR_W]),
      .elem  (dec[i])
    );
  end

  // Push count and ready; flush suppresses both.
  always_comb begin
    iq_lim   = (iq_size_left > CW'(WIDTH)) ? CW'(WIDTH) : iq_size_left;
    push     = '0;
    if (!flush) begin
      push = (occ_q < iq_lim) ? occ_q : iq_lim;
    end
    in_ready = (occ_q == push) && !flush;
  end

  // Compact valid lanes to the bottom in ascending lane order.
  always_comb begin
    load_cnt = '0;
    for (int k = 0; k < int'(WIDTH); k++) begin
      comp[k] = '0;
    end
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (in_valid[i]) begin
        for (int k = 0; k < int'(WIDTH); k++) begin
          if (load_cnt == CW'(k)) begin
            comp[k] = dec[i];
          end
        end
        load_cnt = load_cnt + CW'(1);
      end
    end
  end

  // Drop the pushed entries; entries at or above occ are always zero, so
  // zero-fill keeps the unused tail clear.
  always_comb begin
    for (int k = 0; k < int'(WIDTH); k++) begin
      shifted[k] = '0;
      for (int j = 0; j < int'(WIDTH); j++) begin
        if (j == k + int'(push)) begin
          shifted[k] = buf_q[j];
        end
      end
    end
  end

  // Next buffer state: flush, then load on ready, else partial push.
  always_comb begin
    occ_d = occ_q;
    for (int k = 0; k < int'(WIDTH); k++) begin
      buf_d[k] = buf_q[k];
    end
    if (flush) begin
      occ_d = '0;
      for (int k = 0; k < int'(WIDTH); k++) begin
        buf_d[k] = '0;
      end
    end else if (in_ready) begin
      occ_d = load_cnt;
      for (int k = 0; k < int'(WIDTH); k++) begin
        buf_d[k] = comp[k];
      end
    end else begin
      occ_d = occ_q - push;
      for (int k = 0; k < int'(WIDTH); k++) begin
        buf_d[k] = shifted[k];
      end
    end
  end

  // Saturating count of cycles where buffered lanes could not all leave.
  always_comb begin
    stall_count_d = stall_count_q;
    if (!flush && (occ_q != '0) && (push < occ_q) && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q         <= '0;
      stall_count_q <= '0;
      for (int k = 0; k < int'(WIDTH); k++) begin
        buf_q[k] <= '0;
      end
    end else begin
      occ_q         <= occ_d;
      stall_count_q <= stall_count_d;
      for (int k = 0; k < int'(WIDTH); k++) begin
        buf_q[k] <= buf_d[k];
      end
    end
  end

  for (genvar k = 0; k < WIDTH; k++) begin : g_out
    assign issue_queue_element[k*IQ_W +: IQ_W] = buf_q[k];
  end

  assign issue_queue_push_number = push;
  assign stall_count             = stall_count_q;

endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: randomized and directed stimulus for decode_pipe (WIDTH=4),
// checked every cycle against a queue-based model of the lane buffer.
module tb_decode_pipe;

  localparam int unsigned W    = 4;
  localparam int unsigned CW   = 3;
  localparam int unsigned DR_W = 32;
  localparam int unsigned IQ_W = 34;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 flush;
  logic [W-1:0]         in_valid;
  logic [W*DR_W-1:0]    decode_require;
  logic                 in_ready;
  logic [W*IQ_W-1:0]    issue_queue_element;
  logic [CW-1:0]        issue_queue_push_number;
  logic [CW-1:0]        iq_size_left;
  logic [31:0]          stall_count;

  always #5 clk = ~clk;

  decode_pipe #(.WIDTH(W)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .flush                   (flush),
    .in_valid                (in_valid),
    .decode_require          (decode_require),
    .in_ready                (in_ready),
    .issue_queue_element     (issue_queue_element),
    .issue_queue_push_number (issue_queue_push_number),
    .iq_size_left            (iq_size_left),
    .stall_count             (stall_count)
  );

  logic [IQ_W-1:0] mq[$];
  logic [31:0]     ms;
  logic [31:0]     lanes[W];
  logic [6:0]      ops[7] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h6f};
  int              n_checks = 0;
  int              n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference decode straight from the element layout.
  function automatic logic [IQ_W-1:0] ref_decode(input logic [31:0] ins);
    logic [6:0]  op;
    logic [1:0]  fu;
    logic        wr;
    logic [11:0] imm;
    op = ins[6:0];
    if (op == 7'h33 || op == 7'h13)      fu = 2'd0;
    else if (op == 7'h03 || op == 7'h23) fu = 2'd1;
    else if (op == 7'h63)                fu = 2'd2;
    else                                 fu = 2'd3;
    wr  = !(op == 7'h23 || op == 7'h63);
    imm = (op == 7'h23) ? {ins[31:25], ins[11:7]} : ins[31:20];
    return {1'b1, fu, wr, ins[11:7], ins[19:15], ins[24:20], ins[14:12], imm};
  endfunction

  task automatic rand_lanes();
    logic [31:0] r;
    for (int i = 0; i < int'(W); i++) begin
      r        = $urandom;
      lanes[i] = {r[31:7], ops[$urandom_range(0, 6)]};
    end
  endtask

  task automatic drive_lanes();
    for (int i = 0; i < int'(W); i++) begin
      decode_require[i*DR_W +: DR_W] = lanes[i];
    end
  endtask

  // One clock cycle: drive, check against the model, advance the model.
  task automatic cycle(input logic fl, input logic [W-1:0] v, input logic [CW-1:0] iq);
    int   sz, lim, push;
    logic rdy;
    flush        = fl;
    in_valid     = v;
    iq_size_left = iq;
    drive_lanes();
    sz   = mq.size();
    lim  = (int'(iq) > int'(W)) ? int'(W) : int'(iq);
    push = fl ? 0 : ((sz < lim) ? sz : lim);
    rdy  = (sz == push) && !fl;
    #1;
    check("push_number", 64'(issue_queue_push_number), 64'(push));
    check("in_ready", 64'(in_ready), 64'(rdy));
    for (int k = 0; k < int'(W); k++) begin
      check($sformatf("elem%0d", k), 64'(issue_queue_element[k*IQ_W +: IQ_W]),
            (k < sz) ? 64'(mq[k]) : 64'd0);
    end
    check("stall_count", 64'(stall_count), 64'(ms));
    @(posedge clk);
    if (fl) begin
      mq.delete();
    end else begin
      for (int n = 0; n < push; n++) void'(mq.pop_front());
      if (rdy) begin
        for (int i = 0; i < int'(W); i++) begin
          if (v[i]) mq.push_back(ref_decode(lanes[i]));
        end
      end
    end
    if (!fl && sz > 0 && push < sz && ms != 32'hFFFF_FFFF) ms++;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_push"}, 64'(issue_queue_push_number), 64'd0);
    check({tag, "_stall"}, 64'(stall_count), 64'd0);
    for (int k = 0; k < int'(W); k++) begin
      check($sformatf("%s_elem%0d", tag, k), 64'(issue_queue_element[k*IQ_W +: IQ_W]), 64'd0);
    end
  endtask

  initial begin
    rst          = 1'b1;
    flush        = 1'b0;
    in_valid     = '1;
    iq_size_left = 3'd4;
    ms           = '0;
    rand_lanes();
    drive_lanes();
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Full throughput.
    repeat (8) begin
      rand_lanes();
      cycle(1'b0, 4'b1111, 3'd4);
    end
    cycle(1'b0, 4'b0000, 3'd4);

    // Partial push with upstream holding the bundle stable.
    rand_lanes();
    cycle(1'b0, 4'b1111, 3'd4);
    cycle(1'b0, 4'b1111, 3'd1);
    cycle(1'b0, 4'b1111, 3'd2);
    cycle(1'b0, 4'b1111, 3'd4);
    cycle(1'b0, 4'b0000, 3'd4);

    // Compaction across gaps.
    rand_lanes();
    cycle(1'b0, 4'b1010, 3'd4);
    cycle(1'b0, 4'b0000, 3'd2);
    cycle(1'b0, 4'b0000, 3'd4);

    // Flush with occ=3 and a valid bundle presented.
    rand_lanes();
    cycle(1'b0, 4'b0111, 3'd0);
    rand_lanes();
    cycle(1'b1, 4'b1111, 3'd4);
    cycle(1'b0, 4'b0000, 3'd4);

    // Blocked queue for 5 cycles, then iq_size_left above WIDTH.
    rand_lanes();
    cycle(1'b0, 4'b1001, 3'd0);
    repeat (5) cycle(1'b0, 4'b1111, 3'd0);
    cycle(1'b0, 4'b0000, 3'd7);

    // Saturation near the top of the counter, then reset mid-stall.
    rand_lanes();
    cycle(1'b0, 4'b0011, 3'd0);
    force dut.stall_count_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_count_q;
    ms = 32'hFFFF_FFFD;
    repeat (5) cycle(1'b0, 4'b1111, 3'd0);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    mq.delete();
    ms = '0;
    @(negedge clk);
    rst = 1'b0;

    // Random traffic.
    repeat (300) begin
      rand_lanes();
      cycle(($urandom_range(0, 15) == 0), W'($urandom), CW'($urandom_range(0, 7)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
